i2s_rx: RTL and testbench

Front-end I2S receiver that deserializes the ADC/codec serial stream into signed 16-bit samples. It feeds the three-band equalizer directly: `audio_out` drives the EQ sample input and `l_r_clk` drives the EQ's per-edge sample strobe. It also exposes per-channel registers and a valid pulse for other consumers. All I2S pins are asynchronous to `clk` and are oversampled.

---
 rtl/i2s_rx_if.sv | 38 +++
 rtl/i2s_rx.sv | 173 +++++++++++++++++
 tb/tb_i2s_rx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/i2s_rx_if.sv
// I2S receiver bus: serial pins toward the receiver, deserialized samples away from it.
interface i2s_rx_if;
    logic               i2s_bclk;
    logic               i2s_lrck;
    logic               i2s_sd;
    logic signed [15:0] audio_out;
    logic               l_r_clk;
    logic signed [15:0] left_sample;
    logic signed [15:0] right_sample;
    logic               sample_valid;
    logic               frame_err;

    // Receiver side: samples the pins, drives the sample outputs.
    modport master (
        input  i2s_bclk,
        input  i2s_lrck,
        input  i2s_sd,
        output audio_out,
        output l_r_clk,
        output left_sample,
        output right_sample,
        output sample_valid,
        output frame_err
    );

    // Codec/consumer side: drives the pins, reads the samples.
    modport slave (
        output i2s_bclk,
        output i2s_lrck,
        output i2s_sd,
        input  audio_out,
        input  l_r_clk,
        input  left_sample,
        input  right_sample,
        input  sample_valid,
        input  frame_err
    );
endinterface

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples bclk/lrck/sd, detects bclk rising edges and
// deserializes the MSB-first two's-complement word of each channel slot.
// The bclk_rise on which lrck changes carries the one-bit I2S delay (it holds
// the LSB of the previous word), so the MSB arrives on the following rise.
// SYNC_STAGES must be at least 2.
module i2s_rx #(
    parameter int SAMPLE_BITS = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic     clk,
    input  logic     reset,
    i2s_rx_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_SHIFT,
        ST_DONE,
        ST_WAIT
    } state_t;

    logic [SYNC_STAGES-1:0] bclk_sync_q;
    logic [SYNC_STAGES-1:0] lrck_sync_q;
    logic [SYNC_STAGES-1:0] sd_sync_q;
    logic                   bclk_d1_q;

    logic                   bclk_s;
    logic                   lrck_s;
    logic                   sd_s;
    logic                   bclk_rise;
    logic                   boundary;

    state_t                 state_q;
    logic [15:0]            shreg_q;
    logic [4:0]             bit_cnt_q;
    logic                   chan_q;
    logic                   lrck_prev_q;
    logic                   primed_q;
    logic                   pend_q;
    logic                   pend_chan_q;

    logic signed [15:0]     audio_out_q;
    logic signed [15:0]     left_sample_q;
    logic signed [15:0]     right_sample_q;
    logic                   l_r_clk_q;
    logic                   sample_valid_q;
    logic                   frame_err_q;

    // Synchronizer chains for the three asynchronous pins plus the bclk edge-detect delay.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bclk_sync_q <= '0;
            lrck_sync_q <= '0;
            sd_sync_q   <= '0;
            bclk_d1_q   <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], bus.i2s_bclk};
            lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], bus.i2s_lrck};
            sd_sync_q   <= {sd_sync_q[SYNC_STAGES-2:0], bus.i2s_sd};
            bclk_d1_q   <= bclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
    assign lrck_s    = lrck_sync_q[SYNC_STAGES-1];
    assign sd_s      = sd_sync_q[SYNC_STAGES-1];
    assign bclk_rise = bclk_s & ~bclk_d1_q;
    // primed_q ignores the first rise after reset, when lrck_prev_q is only a reset value
    // and a mismatch would fake a boundary in the middle of a slot.
    assign boundary  = bclk_rise & primed_q & (lrck_s != lrck_prev_q);

    // Slot-tracking state machine with registered sample outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            shreg_q        <= '0;
            bit_cnt_q      <= '0;
            chan_q         <= 1'b0;
            lrck_prev_q    <= 1'b0;
            primed_q       <= 1'b0;
            pend_q         <= 1'b0;
            pend_chan_q    <= 1'b0;
            audio_out_q    <= '0;
            left_sample_q  <= '0;
            right_sample_q <= '0;
            l_r_clk_q      <= 1'b0;
            sample_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            sample_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
            if (bclk_rise) begin
                lrck_prev_q <= lrck_s;
                primed_q    <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (boundary) begin
                        chan_q  <= lrck_s;
                        state_q <= ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    // The boundary rise already delivered the delay bit; arm the shifter.
                    bit_cnt_q <= '0;
                    if (boundary) begin
                        frame_err_q <= 1'b1;
                        chan_q      <= lrck_s;
                        shreg_q     <= '0;
                    end else begin
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bclk_rise) begin
                        if (bit_cnt_q == 5'(SAMPLE_BITS - 1)) begin
                            // With minimal-length slots the LSB shares its rise with the next
                            // boundary: finish this word, then start the new slot.
                            shreg_q   <= {shreg_q[14:0], sd_s};
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            state_q   <= ST_DONE;
                            if (boundary) begin
                                pend_q      <= 1'b1;
                                pend_chan_q <= lrck_s;
                            end
                        end else if (boundary) begin
                            frame_err_q <= 1'b1;
                            shreg_q     <= '0;
                            chan_q      <= lrck_s;
                            state_q     <= ST_DELAY;
                        end else begin
                            shreg_q   <= {shreg_q[14:0], sd_s};
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (chan_q) begin
                        right_sample_q <= shreg_q;
                    end else begin
                        left_sample_q <= shreg_q;
                    end
                    audio_out_q    <= shreg_q;
                    l_r_clk_q      <= chan_q;
                    sample_valid_q <= 1'b1;
                    if (pend_q) begin
                        pend_q  <= 1'b0;
                        chan_q  <= pend_chan_q;
                        state_q <= ST_DELAY;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (boundary) begin
                        chan_q  <= lrck_s;
                        state_q <= ST_DELAY;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.audio_out    = audio_out_q;
    assign bus.l_r_clk      = l_r_clk_q;
    assign bus.left_sample  = left_sample_q;
    assign bus.right_sample = right_sample_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.frame_err    = frame_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: an I2S transmitter model drives slots, expected
// words go to a scoreboard queue, a monitor pops and checks on each sample_valid.
module tb_i2s_rx;

    typedef struct packed {
        logic        ch;
        logic [15:0] w;
    } exp_t;

    logic clk;
    logic reset;
    i2s_rx_if bus ();

    i2s_rx #(.SAMPLE_BITS(16), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sb[$];
    int          tests       = 0;
    int          fails       = 0;
    int          valid_cnt   = 0;
    int          err_cnt     = 0;
    int          toggles     = 0;
    int          exp_toggles = 0;
    int          pushes      = 0;
    int          half        = 8;
    logic        carry       = 1'b0;
    logic        last_ch     = 1'b0;
    logic        prev_lr     = 1'b0;
    logic [15:0] last_audio  = 16'h0;
    logic [15:0] last_left   = 16'h0;
    logic [15:0] last_right  = 16'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bit period: data and word select change while bclk is low, receiver samples on the rise.
    task automatic send_bit(input logic l, input logic d);
        bus.i2s_lrck = l;
        bus.i2s_sd   = d;
        repeat (half) @(negedge clk);
        bus.i2s_bclk = 1'b1;
        repeat (half) @(negedge clk);
        bus.i2s_bclk = 1'b0;
    endtask

    // One slot of len bit periods; period 0 carries the previous word's LSB (I2S delay bit).
    task automatic send_slot(input logic ch, input logic [15:0] w, input int len, input bit push);
        exp_t e;
        if (push) begin
            e.ch = ch;
            e.w  = w;
            sb.push_back(e);
            pushes++;
            if (ch != last_ch) exp_toggles++;
            last_ch = ch;
        end
        for (int p = 0; p < len; p++) begin
            if (p == 0)       send_bit(ch, carry);
            else if (p <= 16) send_bit(ch, w[16-p]);
            else              send_bit(ch, 1'($urandom));
        end
        carry = (len == 16) ? w[0] : 1'($urandom);
    endtask

    task automatic chk_outputs_zero();
        chk("rst_audio_out", {16'd0, bus.audio_out}, 32'd0);
        chk("rst_left", {16'd0, bus.left_sample}, 32'd0);
        chk("rst_right", {16'd0, bus.right_sample}, 32'd0);
        chk("rst_l_r_clk", {31'd0, bus.l_r_clk}, 32'd0);
        chk("rst_valid", {31'd0, bus.sample_valid}, 32'd0);
        chk("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    endtask

    // Monitor: scoreboard pop on each sample, hold check on each frame error, l_r_clk edge count.
    always @(negedge clk) begin
        exp_t e;
        if (bus.sample_valid === 1'b1) begin
            valid_cnt++;
            chk("valid_has_expect", {31'd0, sb.size() == 0}, 32'd0);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("audio_out", {16'd0, bus.audio_out}, {16'd0, e.w});
                chk("l_r_clk", {31'd0, bus.l_r_clk}, {31'd0, e.ch});
                if (e.ch) chk("right_sample", {16'd0, bus.right_sample}, {16'd0, e.w});
                else      chk("left_sample", {16'd0, bus.left_sample}, {16'd0, e.w});
                chk("valid_err_overlap", {31'd0, bus.frame_err}, 32'd0);
                last_audio = e.w;
                if (e.ch) last_right = e.w;
                else      last_left = e.w;
                $display("[TB] sample ch=%0d word=%h", e.ch, e.w);
            end
        end
        if (bus.frame_err === 1'b1) begin
            err_cnt++;
            chk("err_hold_audio", {16'd0, bus.audio_out}, {16'd0, last_audio});
            chk("err_hold_left", {16'd0, bus.left_sample}, {16'd0, last_left});
            chk("err_hold_right", {16'd0, bus.right_sample}, {16'd0, last_right});
            $display("[TB] frame_err pulse");
        end
        if (bus.l_r_clk !== prev_lr) toggles++;
        prev_lr = bus.l_r_clk;
    end

    initial begin
        bus.i2s_bclk = 1'b0;
        bus.i2s_lrck = 1'b0;
        bus.i2s_sd   = 1'b0;
        reset        = 1'b0;

        // Reset held with random pin activity.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.i2s_bclk = 1'($urandom);
            bus.i2s_lrck = 1'($urandom);
            bus.i2s_sd   = 1'($urandom);
        end
        chk_outputs_zero();

        // Release in the middle of a right slot; nothing may come out of it.
        bus.i2s_bclk = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'($urandom));
        reset = 1'b1;
        for (int i = 0; i < 6; i++) send_bit(1'b1, 1'($urandom));
        chk_outputs_zero();
        chk("no_valid_after_release", valid_cnt, 32'd0);

        // Standard stereo frames, 32-bit slots.
        send_slot(1'b0, 16'h7FFF, 32, 1'b1);
        send_slot(1'b1, 16'h8001, 32, 1'b1);
        send_slot(1'b0, 16'h7FFF, 32, 1'b1);
        send_slot(1'b1, 16'h8001, 32, 1'b1);
        chk("std_left", {16'd0, bus.left_sample}, 32'h7FFF);
        chk("std_right", {16'd0, bus.right_sample}, 32'h8001);
        chk("std_audio", {16'd0, bus.audio_out}, 32'h8001);
        chk("std_lr", {31'd0, bus.l_r_clk}, 32'd1);
        chk("std_valid_cnt", valid_cnt, 32'd4);

        // Bit alignment with 16-bit slots: LSB rides on the next slot's boundary rise.
        send_slot(1'b0, 16'h1234, 16, 1'b1);
        send_slot(1'b1, 16'h5678, 16, 1'b1);
        chk("align_left", {16'd0, bus.left_sample}, 32'h1234);

        // Short slot: right lasts 1 delay bit + 10 data bits, then left 0xA5A5.
        send_slot(1'b0, 16'h0F0F, 32, 1'b1);
        chk("align_right", {16'd0, bus.right_sample}, 32'h5678);
        send_slot(1'b1, 16'hFFFF, 11, 1'b0);
        send_slot(1'b0, 16'hA5A5, 32, 1'b1);
        chk("short_err_cnt", err_cnt, 32'd1);
        chk("short_next_left", {16'd0, bus.left_sample}, 32'hA5A5);

        // Long 24-bit slots with junk after the word.
        send_slot(1'b1, 16'h1357, 24, 1'b1);
        send_slot(1'b0, 16'hC3C3, 24, 1'b1);
        chk("long_left", {16'd0, bus.left_sample}, 32'hC3C3);
        chk("long_right", {16'd0, bus.right_sample}, 32'h1357);
        chk("long_no_err", err_cnt, 32'd1);

        // Continuous random stream at the minimum 8x oversampling, 16-bit slots.
        half = 4;
        for (int f = 0; f < 150; f++) begin
            send_slot(1'b1, 16'($urandom), 16, 1'b1);
            send_slot(1'b0, 16'($urandom), 16, 1'b1);
        end
        send_slot(1'b1, 16'h0BAD, 32, 1'b1);

        for (int i = 0; i < 4000 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", sb.size(), 32'd0);
        chk("valid_total", valid_cnt, pushes);
        chk("lr_toggles", toggles, exp_toggles);
        chk("err_total", err_cnt, 32'd1);
        chk("final_right", {16'd0, bus.right_sample}, 32'h0BAD);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
